alu_mdu_stage: RTL and testbench
================================

# alu_mdu_stage

Parametrised execute-stage arithmetic unit for the RISC-V pipeline. It merges the ALU control decode with a registered ALU, a single-cycle multiplier and an optional iterative divider behind a valid/ready handshake. A multi-cycle divide can therefore stall the pipeline cleanly. It sits between the ID/EX pipeline register and the EX/MEM register, and replaces the purely combinational ALU decode path.

## Interface
- XLEN, 32, datapath width; legal values are 32 and 64.
- SHW, $clog2(XLEN), shift-amount width (derived; do not override).
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush; aborts the in-flight operation.
- in_valid  in  1  operands and decode fields are valid.
- in_ready  out  1  the unit can accept an operation this cycle.
- op5  in  1  opcode bit 5 (1 = R-type, 0 = I-type).
- funct3  in  3  instruction funct3.
- funct7b5  in  1  instruction funct7 bit 5.
- funct7b0  in  1  instruction funct7 bit 0 (M-extension select).
- ALUOp  in  2  main-decoder class: 00 add, 01 sub, 10 funct-decoded, 11 reserved (treated as add).
- SrcA, SrcB  in  XLEN  operands.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- result  out  XLEN  registered result.
- zero  out  1  registered (result == 0).
- illegal  out  1  the operation was an unsupported encoding (see Configuration).

## Operation
- An operation is accepted when in_valid & in_ready. in_ready = !busy & (!out_valid | out_ready).
- ALUControl encoding:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra.
  - 1001 sltu (funct3 011; this op is new).
  - 1010 mul, 1011 mulh, 1100 mulhsu, 1101 mulhu, 1110 div/divu, 1111 rem/remu.
- The M path is selected when ALUOp==10 & op5 & funct7b0. Subtract is selected when funct3==000 & op5 & funct7b5. For funct3==101, funct7b5 selects sra over srl.
- Shifts use SrcB[SHW-1:0]. slt is signed and sltu is unsigned; both produce a 0/1 result zero-extended to XLEN.
- mul returns the low XLEN bits of the 2·XLEN product. The mulh variants return the high XLEN bits with signed×signed, signed×unsigned or unsigned×unsigned interpretation respectively.
- Divide is restoring, one quotient bit per cycle, and operates on operand magnitudes. Signs are corrected at the end: quotient is negated if the signs differ, remainder takes the dividend's sign. funct3[0] = 1 selects unsigned.
- Divide by zero: quotient = all ones, remainder = SrcA.
- Signed overflow (most-negative ÷ −1): quotient = SrcA, remainder = 0.
- FSM states:
  - IDLE: accept an op. Single-cycle ops load the output register; a divide goes to DIV.
  - DIV: run XLEN iterations, then go to FIX.
  - FIX: write the corrected result, set out_valid, go to IDLE.
- busy = (state != IDLE).
- The output register holds result, zero and illegal stable while out_valid & !out_ready.

## Timing
- Reset values: out_valid 0, result 0, zero 0, illegal 0, state IDLE, iteration counter 0. in_ready is 1 in the cycle after reset deasserts.
- Non-divide ops: out_valid rises the cycle after acceptance (latency 1). With out_ready held high, the unit sustains one op per cycle.
- Divide: out_valid rises exactly XLEN+2 cycles after the accept edge. This includes the zero-divisor and overflow cases (fixed latency). in_ready is 0 throughout.
- flush has priority over everything except reset:
  - out_valid clears next cycle and state returns to IDLE.
  - An in_valid asserted in the same cycle is not accepted.
- reset during DIV aborts the divide. No result is produced.
- out_ready is ignored while out_valid = 0.

## Configuration
- ALU_MDU_DIV_EN defined: the divider and DIV/FIX states are built as described above.
- ALU_MDU_DIV_EN undefined:
  - Control codes 1110 and 1111 complete in 1 cycle with result = 0 and illegal = 1.
  - The FSM reduces to IDLE; busy is constantly 0.
- illegal is also 1 for ALUOp==10 with funct3 and funct7 combinations outside the table above, regardless of the macro.

## Structure
- Package alu_pkg holds the 4-bit ALUControl localparams, the FSM state typedef, and the XLEN legality check.
- Sub-module div_iter: the iterative magnitude divider, with start/done, an XLEN-cycle counter and a sign-fix stage. It is instantiated only under ALU_MDU_DIV_EN.
- The decode, multiplier, ALU and output register stay in the top module.

## Test plan
- XLEN=32, add with SrcA=5, SrcB=−5 → one cycle later result=0, zero=1, out_valid=1.
- sra with SrcA=0x80000000, SrcB=0x24 (shift by 4) → result=0xF8000000. sltu with SrcA=1, SrcB=0xFFFFFFFF → result=1.
- mulh with 0x80000000 × 0x80000000 → result=0x40000000. mulhu with 0xFFFFFFFF × 2 → result=1.
- div 7 by −2 → quotient −3, out_valid exactly 34 cycles after the accept edge. rem → 1. div by 0 → 0xFFFFFFFF. div 0x80000000 by −1 → 0x80000000. in_ready is 0 throughout each divide.
- Back-pressure: hold out_ready=0 for 3 cycles after a result → result stable, in_ready=0. Then release → next op accepted in the same cycle.
- flush asserted in DIV cycle 10 together with in_valid → no result and no accept; in_ready=1 next cycle. Without ALU_MDU_DIV_EN, divu → result 0, illegal=1 after 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the execute-stage arithmetic unit: the 4-bit
//   ALUControl codes, the sequencing state type and the XLEN legality check.
//   No ports; imported by alu_mdu_stage.
package alu_pkg;

    // ALUControl codes produced by the decode and consumed by the datapath
    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_AND    = 4'b0010;
    localparam logic [3:0] ALU_OR     = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SLT    = 4'b0101;
    localparam logic [3:0] ALU_SLL    = 4'b0110;
    localparam logic [3:0] ALU_SRL    = 4'b0111;
    localparam logic [3:0] ALU_SRA    = 4'b1000;
    localparam logic [3:0] ALU_SLTU   = 4'b1001;
    localparam logic [3:0] ALU_MUL    = 4'b1010;
    localparam logic [3:0] ALU_MULH   = 4'b1011;
    localparam logic [3:0] ALU_MULHSU = 4'b1100;
    localparam logic [3:0] ALU_MULHU  = 4'b1101;
    localparam logic [3:0] ALU_DIV    = 4'b1110;
    localparam logic [3:0] ALU_REM    = 4'b1111;

    // Sequencing states; only IDLE is reachable when the divider is not built
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DIV  = 2'b01,
        FIX  = 2'b10
    } stateT;

    // The datapath only supports RV32 and RV64 widths
    function automatic bit xlenLegal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/div_iter.sv
// div_iter
//   Restoring divider working on operand magnitudes, one quotient bit per
//   cycle, followed by a one-cycle sign-fix stage.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     abort_i             drops any divide in progress
//     start_i             load operands and begin (ignored while aborting)
//     signed_i            1 = signed divide, 0 = unsigned
//     dividend_i/divisor_i operands, sampled on start_i
//     fixing_o            iterations finished; sign-fix runs this cycle
//     done_o              one-cycle pulse, quotient_o/remainder_o are final
//     quotient_o/remainder_o corrected results
//   Latency: start edge, XLEN iteration edges, one sign-fix edge.
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            abort_i,
    input  logic            start_i,
    input  logic            signed_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            fixing_o,
    output logic            done_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(XLEN);

    logic            running_q;
    logic            done_q;
    logic            negQuo_q;
    logic            negRem_q;
    logic            divZero_q;
    logic [CW-1:0]   count_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] divisor_q;
    logic [XLEN-1:0] dividend_q;
    logic [XLEN-1:0] quotient_q;
    logic [XLEN-1:0] remainder_q;

    logic            dividendNeg;
    logic            divisorNeg;
    logic [XLEN-1:0] dividendMag;
    logic [XLEN-1:0] divisorMag;
    logic [XLEN:0]   shifted;
    logic            fits;
    logic [XLEN-1:0] remDiff;
    logic [XLEN-1:0] remNext;
    logic [XLEN-1:0] quoNext;

    // Operand magnitudes at start, and one restoring step on the partial
    // remainder. The shifted remainder needs one extra bit since it can
    // reach just under twice the divisor.
    always_comb begin
        dividendNeg = signed_i & dividend_i[XLEN-1];
        divisorNeg  = signed_i & divisor_i[XLEN-1];
        dividendMag = dividendNeg ? -dividend_i : dividend_i;
        divisorMag  = divisorNeg  ? -divisor_i  : divisor_i;
        shifted     = {rem_q, quo_q[XLEN-1]};
        fits        = shifted >= {1'b0, divisor_q};
        remDiff     = shifted[XLEN-1:0] - divisor_q;
        remNext     = fits ? remDiff : shifted[XLEN-1:0];
        quoNext     = {quo_q[XLEN-2:0], fits};
    end

    // Iteration control. Divide-by-zero is forced in the fix stage rather
    // than short-circuited, so every divide has the same latency. The
    // most-negative / -1 case falls out of the magnitude arithmetic.
    always_ff @(posedge clk) begin
        if (reset) begin
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            negQuo_q    <= 1'b0;
            negRem_q    <= 1'b0;
            divZero_q   <= 1'b0;
            count_q     <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            divisor_q   <= '0;
            dividend_q  <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                running_q <= 1'b0;
                count_q   <= '0;
            end else if (start_i) begin
                running_q  <= 1'b1;
                count_q    <= '0;
                quo_q      <= dividendMag;
                rem_q      <= '0;
                divisor_q  <= divisorMag;
                dividend_q <= dividend_i;
                negQuo_q   <= dividendNeg ^ divisorNeg;
                negRem_q   <= dividendNeg;
                divZero_q  <= (divisor_i == '0);
            end else if (running_q && (count_q == LAST)) begin
                if (divZero_q) begin
                    quotient_q  <= '1;
                    remainder_q <= dividend_q;
                end else begin
                    quotient_q  <= negQuo_q ? -quo_q : quo_q;
                    remainder_q <= negRem_q ? -rem_q : rem_q;
                end
                running_q <= 1'b0;
                count_q   <= '0;
                done_q    <= 1'b1;
            end else if (running_q) begin
                quo_q   <= quoNext;
                rem_q   <= remNext;
                count_q <= count_q + CW'(1);
            end
        end
    end

    assign fixing_o    = running_q && (count_q == LAST);
    assign done_o      = done_q;
    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;

endmodule

// File: rtl/alu_mdu_stage.sv
// alu_mdu_stage
//   Execute-stage arithmetic unit: ALU control decode, registered ALU,
//   single-cycle multiplier and an optional iterative divider behind a
//   valid/ready handshake.
//   Build option: define ALU_MDU_DIV_EN to build the divider and the
//   DIV/FIX states; otherwise divide/remainder complete in one cycle with
//   result 0 and illegal set.
//   Ports:
//     clk, reset, flush     clock, synchronous reset, synchronous abort
//     in_valid/in_ready     operation handshake
//     op5, funct3, funct7b5, funct7b0, ALUOp   decode fields
//     SrcA, SrcB            operands
//     out_valid/out_ready   result handshake
//     result, zero, illegal registered outputs
module alu_mdu_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            op5,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            funct7b0,
    input  logic [1:0]      ALUOp,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);
    if (!xlenLegal(XLEN)) begin : gBadXlen
        $error("alu_mdu_stage: XLEN must be 32 or 64");
    end

    logic [3:0]        aluCtrl;
    logic              illegalDec;
    logic              illegalOp;
    logic              isDiv;
    logic              divPath;
    logic              busy;
    logic              accept;
    logic              aSign;
    logic              bSign;
    logic [2*XLEN-1:0] aExt;
    logic [2*XLEN-1:0] bExt;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   result_d;

    logic              outValid_q;
    logic [XLEN-1:0]   result_q;
    logic              zero_q;
    logic              illegal_q;

    // ALUOp 11 is reserved and falls back to add. Only the funct-decoded
    // class can be illegal: R-type funct7b5 is meaningful only for sub/sra,
    // and the M path requires funct7b5 clear.
    always_comb begin
        aluCtrl    = ALU_ADD;
        illegalDec = 1'b0;
        case (ALUOp)
            2'b01: aluCtrl = ALU_SUB;
            2'b10: begin
                if (op5 && funct7b0) begin
                    illegalDec = funct7b5;
                    case (funct3)
                        3'b000:  aluCtrl = ALU_MUL;
                        3'b001:  aluCtrl = ALU_MULH;
                        3'b010:  aluCtrl = ALU_MULHSU;
                        3'b011:  aluCtrl = ALU_MULHU;
                        3'b100,
                        3'b101:  aluCtrl = ALU_DIV;
                        default: aluCtrl = ALU_REM;
                    endcase
                end else begin
                    illegalDec = op5 && funct7b5 && (funct3 != 3'b000) && (funct3 != 3'b101);
                    case (funct3)
                        3'b000:  aluCtrl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                        3'b001:  aluCtrl = ALU_SLL;
                        3'b010:  aluCtrl = ALU_SLT;
                        3'b011:  aluCtrl = ALU_SLTU;
                        3'b100:  aluCtrl = ALU_XOR;
                        3'b101:  aluCtrl = funct7b5 ? ALU_SRA : ALU_SRL;
                        3'b110:  aluCtrl = ALU_OR;
                        default: aluCtrl = ALU_AND;
                    endcase
                end
            end
            default: aluCtrl = ALU_ADD;
        endcase
    end

    assign isDiv = (aluCtrl == ALU_DIV) || (aluCtrl == ALU_REM);

`ifdef ALU_MDU_DIV_EN
    assign illegalOp = illegalDec;
    assign divPath   = isDiv;
`else
    assign illegalOp = illegalDec | isDiv;
    assign divPath   = 1'b0;
`endif

    // One shared multiplier: operands are sign- or zero-extended to 2*XLEN
    // so the low 2*XLEN bits of the product are right for every variant.
    always_comb begin
        aSign   = ((aluCtrl == ALU_MULH) || (aluCtrl == ALU_MULHSU)) && SrcA[XLEN-1];
        bSign   = (aluCtrl == ALU_MULH) && SrcB[XLEN-1];
        aExt    = {{XLEN{aSign}}, SrcA};
        bExt    = {{XLEN{bSign}}, SrcB};
        product = aExt * bExt;
    end

    // Single-cycle datapath; divide codes produce 0 here and, when the
    // divider is built, are replaced by the divider result in FIX.
    always_comb begin
        result_d = '0;
        case (aluCtrl)
            ALU_ADD:    result_d = SrcA + SrcB;
            ALU_SUB:    result_d = SrcA - SrcB;
            ALU_AND:    result_d = SrcA & SrcB;
            ALU_OR:     result_d = SrcA | SrcB;
            ALU_XOR:    result_d = SrcA ^ SrcB;
            ALU_SLT:    result_d = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            ALU_SLTU:   result_d = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
            ALU_SLL:    result_d = SrcA << SrcB[SHW-1:0];
            ALU_SRL:    result_d = SrcA >> SrcB[SHW-1:0];
            ALU_SRA:    result_d = $signed(SrcA) >>> SrcB[SHW-1:0];
            ALU_MUL:    result_d = product[XLEN-1:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  result_d = product[2*XLEN-1:XLEN];
            default:    result_d = '0;
        endcase
    end

`ifdef ALU_MDU_DIV_EN
    stateT           state_q;
    logic            selRem_q;
    logic            divIllegal_q;
    logic            divStart;
    logic            divFixing;
    logic            divDone;
    logic [XLEN-1:0] divQuotient;
    logic [XLEN-1:0] divRemainder;
    logic [XLEN-1:0] divResult;

    assign busy      = (state_q != IDLE);
    assign divStart  = accept && !flush && divPath;
    assign divResult = selRem_q ? divRemainder : divQuotient;

    div_iter #(.XLEN(XLEN)) uDivIter (
        .clk         (clk),
        .reset       (reset),
        .abort_i     (flush),
        .start_i     (divStart),
        .signed_i    (~funct3[0]),
        .dividend_i  (SrcA),
        .divisor_i   (SrcB),
        .fixing_o    (divFixing),
        .done_o      (divDone),
        .quotient_o  (divQuotient),
        .remainder_o (divRemainder)
    );
`else
    assign busy = 1'b0;
`endif

    assign in_ready = !busy && (!outValid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Output register and sequencing. flush outranks everything but reset;
    // the output register only changes on a new load, so it holds while
    // out_valid waits on out_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            outValid_q <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            illegal_q  <= 1'b0;
`ifdef ALU_MDU_DIV_EN
            state_q      <= IDLE;
            selRem_q     <= 1'b0;
            divIllegal_q <= 1'b0;
`endif
        end else if (flush) begin
            outValid_q <= 1'b0;
`ifdef ALU_MDU_DIV_EN
            state_q    <= IDLE;
`endif
        end else if (accept && !divPath) begin
            outValid_q <= 1'b1;
            result_q   <= result_d;
            zero_q     <= (result_d == '0);
            illegal_q  <= illegalOp;
`ifdef ALU_MDU_DIV_EN
        end else if (accept) begin
            outValid_q   <= 1'b0;
            state_q      <= DIV;
            selRem_q     <= (aluCtrl == ALU_REM);
            divIllegal_q <= illegalOp;
        end else if (state_q == DIV) begin
            if (divFixing) begin
                state_q <= FIX;
            end
        end else if (state_q == FIX) begin
            if (divDone) begin
                outValid_q <= 1'b1;
                result_q   <= divResult;
                zero_q     <= (divResult == '0);
                illegal_q  <= divIllegal_q;
                state_q    <= IDLE;
            end
`endif
        end else if (out_ready) begin
            outValid_q <= 1'b0;
        end
    end

    assign out_valid = outValid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_mdu_stage.sv
// tb_alu_mdu_stage
//   Directed bench for alu_mdu_stage at XLEN=32. Divider checks are built
//   when ALU_MDU_DIV_EN is defined; otherwise the divide-as-illegal
//   behaviour is checked instead.
module tb_alu_mdu_stage;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic            op5;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            funct7b0;
    logic [1:0]      ALUOp;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    int assertions = 0;
    int failures   = 0;

    alu_mdu_stage #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op5       (op5),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .funct7b0  (funct7b0),
        .ALUOp     (ALUOp),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Hard stop in case the stimulus itself gets stuck
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] aluOp, input logic o5,
                                 input logic [2:0] f3, input logic b5, input logic b0,
                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        in_valid = v;
        ALUOp    = aluOp;
        op5      = o5;
        funct3   = f3;
        funct7b5 = b5;
        funct7b0 = b0;
        SrcA     = a;
        SrcB     = b;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                               input logic [XLEN-1:0] expected);
        assertions++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkResult(input string tag, input logic [XLEN-1:0] expResult,
                               input logic expIllegal);
        checkOutput({tag, " out_valid"}, {31'b0, out_valid}, 32'd1);
        checkOutput({tag, " result"}, result, expResult);
        checkOutput({tag, " zero"}, {31'b0, zero}, {31'b0, (expResult == 32'd0)});
        checkOutput({tag, " illegal"}, {31'b0, illegal}, {31'b0, expIllegal});
    endtask

`ifdef ALU_MDU_DIV_EN
    task automatic runDivide(input string tag, input logic [2:0] f3,
                             input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                             input logic [XLEN-1:0] expResult);
        int   lat;
        logic readyLow;
        applyStimulus(1'b1, 2'b10, 1'b1, f3, 1'b0, 1'b1, a, b);
        checkOutput({tag, " in_ready before"}, {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        readyLow = 1'b1;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) readyLow = 1'b0;
            tick();
            lat++;
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(XLEN + 2));
        checkOutput({tag, " in_ready held low"}, {31'b0, readyLow}, 32'd1);
        checkResult(tag, expResult, 1'b0);
    endtask
`endif

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();
        checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset result", result, 32'd0);
        checkOutput("reset zero", {31'b0, zero}, 32'd0);
        checkOutput("reset illegal", {31'b0, illegal}, 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("post-reset in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("post-reset out_valid", {31'b0, out_valid}, 32'd0);

        // Single-cycle ops issued back to back with out_ready high
        applyStimulus(1'b1, 2'b00, 1'b1, 3'b000, 1'b0, 1'b0, 32'd5, 32'hFFFF_FFFB);
        tick();
        checkResult("add 5+-5", 32'd0, 1'b0);
        checkOutput("add in_ready", {31'b0, in_ready}, 32'd1);

        applyStimulus(1'b1, 2'b10, 1'b1, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'h24);
        tick();
        checkResult("sra", 32'hF800_0000, 1'b0);

        applyStimulus(1'b1, 2'b10, 1'b1, 3'b011, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF);
        tick();
        checkResult("sltu", 32'd1, 1'b0);

        applyStimulus(1'b1, 2'b10, 1'b1, 3'b010, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF);
        tick();
        checkResult("slt", 32'd0, 1'b0);

        applyStimulus(1'b1, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0, 32'd3, 32'd5);
        tick();
        checkResult("sub 3-5", 32'hFFFF_FFFE, 1'b0);

        applyStimulus(1'b1, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0, 32'd2, 32'd3);
        tick();
        checkResult("reserved aluop add", 32'd5, 1'b0);

        applyStimulus(1'b1, 2'b10, 1'b1, 3'b000, 1'b1, 1'b0, 32'd9, 32'd4);
        tick();
        checkResult("r-type sub", 32'd5, 1'b0);

        applyStimulus(1'b1, 2'b10, 1'b1, 3'b001, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000);
        tick();
        checkResult("mulh", 32'h4000_0000, 1'b0);

        applyStimulus(1'b1, 2'b10, 1'b1, 3'b011, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2);
        tick();
        checkResult("mulhu", 32'd1, 1'b0);

        applyStimulus(1'b1, 2'b10, 1'b1, 3'b010, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2);
        tick();
        checkResult("mulhsu", 32'hFFFF_FFFF, 1'b0);

        applyStimulus(1'b1, 2'b10, 1'b1, 3'b000, 1'b0, 1'b1, 32'h0001_2345, 32'h100);
        tick();
        checkResult("mul", 32'h0123_4500, 1'b0);

        applyStimulus(1'b1, 2'b10, 1'b1, 3'b001, 1'b0, 1'b0, 32'd1, 32'h21);
        tick();
        checkResult("sll masked", 32'd2, 1'b0);

        applyStimulus(1'b1, 2'b10, 1'b0, 3'b100, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0);
        tick();
        checkResult("xor", 32'h0000_FF00, 1'b0);

        applyStimulus(1'b1, 2'b10, 1'b1, 3'b111, 1'b0, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F);
        tick();
        checkResult("and", 32'h0F00_0F00, 1'b0);

        applyStimulus(1'b1, 2'b10, 1'b1, 3'b111, 1'b0, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F);
        funct3 = 3'b110;
        #1;
        tick();
        checkResult("or", 32'hFF0F_FF0F, 1'b0);

        applyStimulus(1'b1, 2'b10, 1'b1, 3'b001, 1'b1, 1'b0, 32'd1, 32'd3);
        tick();
        checkResult("illegal sll funct7", 32'd8, 1'b1);

        // Back-pressure: result must hold and nothing new may enter
        applyStimulus(1'b1, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'd10, 32'd20);
        tick();
        checkResult("bp first", 32'd30, 1'b0);
        out_ready = 1'b0;
        applyStimulus(1'b1, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1);
        checkOutput("bp in_ready low", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkResult("bp hold", 32'd30, 1'b0);
            checkOutput("bp hold in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp release in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        checkResult("bp next op", 32'd2, 1'b0);

        // Flush with a concurrent in_valid: no accept, out_valid clears
        flush = 1'b1;
        applyStimulus(1'b1, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'd4, 32'd4);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("flush clears out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        checkOutput("flush no accept", {31'b0, out_valid}, 32'd0);
        checkOutput("flush in_ready", {31'b0, in_ready}, 32'd1);
        applyStimulus(1'b1, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'd4, 32'd4);
        tick();
        checkResult("after flush", 32'd8, 1'b0);

`ifdef ALU_MDU_DIV_EN
        runDivide("div 7/-2", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        runDivide("rem 7/-2", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1);
        runDivide("divu 100/7", 3'b101, 32'd100, 32'd7, 32'd14);
        runDivide("div by 0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF);
        runDivide("rem by 0", 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
        runDivide("div overflow", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        runDivide("rem overflow", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Flush in the middle of a divide, together with a new request
        begin
            logic sawValid;
            applyStimulus(1'b1, 2'b10, 1'b1, 3'b100, 1'b0, 1'b1, 32'd50, 32'd5);
            tick();
            in_valid = 1'b0;
            for (int i = 0; i < 9; i++) tick();
            checkOutput("div busy before flush", {31'b0, in_ready}, 32'd0);
            flush = 1'b1;
            applyStimulus(1'b1, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2);
            tick();
            flush    = 1'b0;
            in_valid = 1'b0;
            #1;
            checkOutput("div flush out_valid", {31'b0, out_valid}, 32'd0);
            checkOutput("div flush in_ready", {31'b0, in_ready}, 32'd1);
            sawValid = 1'b0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (out_valid) sawValid = 1'b1;
            end
            checkOutput("div flush no result", {31'b0, sawValid}, 32'd0);
        end
`else
        applyStimulus(1'b1, 2'b10, 1'b1, 3'b101, 1'b0, 1'b1, 32'd100, 32'd7);
        tick();
        checkResult("divu disabled", 32'd0, 1'b1);
        applyStimulus(1'b1, 2'b10, 1'b1, 3'b110, 1'b0, 1'b1, 32'd100, 32'd7);
        checkOutput("rem disabled in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        checkResult("rem disabled", 32'd0, 1'b1);
`endif

        in_valid = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
